// File: rtl/button_pkg.sv
// Shared types and default timing for the push-button conditioning stage.
// BUTTON_DEBOUNCE_AUTOREPEAT_EN enables the REPEAT_* states in button_debounce_pulse.
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESSED     = 2'd1,
        REPEAT_WAIT = 2'd2,
        REPEAT_RUN  = 2'd3
    } button_state_e;

    localparam int unsigned CLK_FREQ_HZ     = 50_000_000;
    localparam int unsigned CYCLES_PER_MS   = CLK_FREQ_HZ / 1000;
    localparam int unsigned DEBOUNCE_MS     = 10;
    localparam int unsigned REPEAT_DELAY_MS = 500;
    localparam int unsigned REPEAT_PERIOD_MS = 100;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES      = CYCLES_PER_MS * DEBOUNCE_MS;
    localparam int unsigned DEFAULT_REPEAT_DELAY_CYCLES  = CYCLES_PER_MS * REPEAT_DELAY_MS;
    localparam int unsigned DEFAULT_REPEAT_PERIOD_CYCLES = CYCLES_PER_MS * REPEAT_PERIOD_MS;

    // Bits needed to hold any value 0..max_count inclusive.
    function automatic int unsigned counter_width(input int unsigned max_count);
        if (max_count < 1) begin
            return 1;
        end
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous single-bit inputs (buttons, switches).
// RESET_VALUE should be the input's idle level so reset does not look like an edge.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_debounce_pulse.sv
// Synchronise, debounce and edge-detect a raw push button into a clean level and press/release strobes.
// Define BUTTON_DEBOUNCE_AUTOREPEAT_EN to add hold-to-repeat press pulses.
module button_debounce_pulse
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES      = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit          ACTIVE_LOW           = 1'b1,
    parameter int unsigned REPEAT_DELAY_CYCLES  = DEFAULT_REPEAT_DELAY_CYCLES,
    parameter int unsigned REPEAT_PERIOD_CYCLES = DEFAULT_REPEAT_PERIOD_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic button_in,
    output logic button_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int unsigned       CNT_W        = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic              RAW_RELEASED = ACTIVE_LOW;

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("button_debounce_pulse: DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY_CYCLES == 0 || REPEAT_PERIOD_CYCLES == 0) begin : g_bad_repeat
        $error("button_debounce_pulse: REPEAT_* cycle counts must be non-zero");
    end

    logic          raw_sync;
    logic          sync_pressed;
    logic          differ;
    logic          accept;
    logic          press_evt;
    logic          release_evt;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    button_state_e    state_q;
    button_state_e    state_d;
    logic             button_level_q;
    logic             button_level_d;
    logic             press_pulse_q;
    logic             press_pulse_d;
    logic             release_pulse_q;
    logic             release_pulse_d;

`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
    localparam logic [31:0] REPEAT_DELAY_LAST  = 32'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [31:0] REPEAT_PERIOD_LAST = 32'(REPEAT_PERIOD_CYCLES - 1);

    logic [31:0] hold_q;
    logic [31:0] hold_d;
`endif

    sync_2ff #(
        .RESET_VALUE (RAW_RELEASED)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (button_in),
        .q   (raw_sync)
    );

    // Any cycle where the input agrees with the accepted level wipes the count.
    always_comb begin
        sync_pressed = ACTIVE_LOW ? ~raw_sync : raw_sync;
        differ       = sync_pressed ^ button_level_q;
        accept       = differ && (cnt_q == CNT_LAST);
        cnt_d        = '0;
        if (differ && !accept) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        press_evt   = 1'b0;
        release_evt = 1'b0;
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
        hold_d      = hold_q;
`endif
        case (state_q)
            RELEASED: begin
                if (accept) begin
                    press_evt = 1'b1;
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
                    state_d   = REPEAT_WAIT;
                    hold_d    = '0;
`else
                    state_d   = PRESSED;
`endif
                end
            end
            PRESSED: begin
                if (accept) begin
                    release_evt = 1'b1;
                    state_d     = RELEASED;
                end
            end
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
            // A debounced release always wins over a repeat due in the same cycle.
            REPEAT_WAIT: begin
                if (accept) begin
                    release_evt = 1'b1;
                    state_d     = RELEASED;
                    hold_d      = '0;
                end else if (hold_q == REPEAT_DELAY_LAST) begin
                    press_evt = 1'b1;
                    state_d   = REPEAT_RUN;
                    hold_d    = '0;
                end else begin
                    hold_d = hold_q + 32'd1;
                end
            end
            REPEAT_RUN: begin
                if (accept) begin
                    release_evt = 1'b1;
                    state_d     = RELEASED;
                    hold_d      = '0;
                end else if (hold_q == REPEAT_PERIOD_LAST) begin
                    press_evt = 1'b1;
                    hold_d    = '0;
                end else begin
                    hold_d = hold_q + 32'd1;
                end
            end
`endif
            default: begin
                state_d = RELEASED;
            end
        endcase

        button_level_d  = (state_d != RELEASED);
        press_pulse_d   = press_evt & enable;
        release_pulse_d = release_evt & enable;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q           <= '0;
            state_q         <= RELEASED;
            button_level_q  <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            state_q         <= state_d;
            button_level_q  <= button_level_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
        end
    end

`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    assign button_level  = button_level_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;

endmodule
